// File: rtl/alarm_pkg.sv
// Shared types and sizing helpers for the alarm clock datapath
// (countdown core, display and buzzer stages).
package alarm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} timer_state_e;

  localparam int ALARM_TIME_W = 9;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Start/pause/stop button conditioning: 2-FF synchroniser, optional debounce
// (BTN_DEBOUNCE_EN), and a one-cycle press pulse on the falling edge.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  // Released level is 1, so reset never fabricates a press.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BTN_DEBOUNCE_EN
  import alarm_pkg::*;

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_stable;
  logic [DB_W-1:0] r_db_cnt;

  // Down-counter reloads whenever the sample agrees with the accepted level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stable <= 1'b1;
      r_db_cnt <= DB_LOAD;
    end else if (r_sync2 == r_stable) begin
      r_db_cnt <= DB_LOAD;
    end else if (r_db_cnt == '0) begin
      r_stable <= r_sync2;
      r_db_cnt <= DB_LOAD;
    end else begin
      r_db_cnt <= r_db_cnt - DB_W'(1);
    end
  end

  assign w_level = r_stable;
`else
  logic w_unused_db;
  assign w_unused_db = (DEBOUNCE_CYCLES > 0);
  assign w_level     = r_sync2;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_press = r_prev & ~w_level;

endmodule

// File: rtl/countdown_core.sv
// Alarm clock timekeeping: seconds prescaler, countdown FSM and alarm timer.
// Button debounce is enabled with BTN_DEBOUNCE_EN (see btn_conditioner).
module countdown_core import alarm_pkg::*; #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TIME_W          = ALARM_TIME_W,
  parameter int ALARM_SECS      = 10,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_btn_n,
  input  logic [TIME_W-1:0] i_load_time,
  output logic [TIME_W-1:0] o_time_remaining,
  output logic              o_running,
  output logic              o_paused,
  output logic              o_alarm,
  output logic              o_sec_tick
);

  localparam int PRE_W = cnt_width(CLK_HZ);
  localparam int ALM_W = cnt_width(ALARM_SECS);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [ALM_W-1:0]  ALM_LOAD = ALM_W'(ALARM_SECS - 1);
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

  timer_state_e      r_state;
  logic [PRE_W-1:0]  r_pre;
  logic [ALM_W-1:0]  r_alarm_cnt;
  logic [TIME_W-1:0] r_time;
  logic              r_running;
  logic              r_paused;
  logic              r_alarm;
  logic              r_sec_tick;
  logic              w_press;
  logic              w_wrap;

  btn_conditioner #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn_n (i_btn_n),
    .o_press (w_press)
  );

  assign w_wrap = (r_pre == PRE_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_pre       <= '0;
      r_alarm_cnt <= '0;
      r_time      <= '0;
      r_running   <= 1'b0;
      r_paused    <= 1'b0;
      r_alarm     <= 1'b0;
      r_sec_tick  <= 1'b0;
    end else begin
      r_sec_tick <= 1'b0;
      case (r_state)
        IDLE: begin
          r_time <= i_load_time;
          if (w_press && (i_load_time != '0)) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_pre     <= '0;
          end
        end

        RUN: begin
          r_pre      <= w_wrap ? '0 : r_pre + PRE_W'(1);
          r_sec_tick <= w_wrap;
          if (w_wrap && (r_time != '0)) begin
            r_time <= r_time - TIME_ONE;
          end
          // Reaching zero outranks a coincident press.
          if (w_wrap && (r_time == TIME_ONE)) begin
            r_state     <= ALARM;
            r_running   <= 1'b0;
            r_alarm     <= 1'b1;
            r_alarm_cnt <= ALM_LOAD;
          end else if (w_press) begin
            r_state   <= PAUSE;
            r_running <= 1'b0;
            r_paused  <= 1'b1;
          end
        end

        PAUSE: begin
          // Prescaler is held so the partial second survives the pause.
          if (w_press) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_paused  <= 1'b0;
          end
        end

        ALARM: begin
          r_pre      <= w_wrap ? '0 : r_pre + PRE_W'(1);
          r_sec_tick <= w_wrap;
          r_time     <= '0;
          if (w_press || (w_wrap && (r_alarm_cnt == '0))) begin
            r_state <= IDLE;
            r_alarm <= 1'b0;
            r_time  <= i_load_time;
          end else if (w_wrap) begin
            r_alarm_cnt <= r_alarm_cnt - ALM_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_time_remaining = r_time;
  assign o_running        = r_running;
  assign o_paused         = r_paused;
  assign o_alarm          = r_alarm;
  assign o_sec_tick       = r_sec_tick;

endmodule
